// File: rtl/mem_ctrl_pkg.sv
// Shared types and encodings for the memory-stage controller.
package mem_ctrl_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 32;

    // RISC-V load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, lane extract/extension for loads, and
// detection of misaligned or unsupported accesses.
module lsu_align
    import mem_ctrl_pkg::*;
(
    input  logic            is_read,
    input  logic            is_write,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_rep,
    output logic [XLEN-1:0] load_data,
    output logic            bad
);

    logic [XLEN-1:0] shifted;

    // Byte enables follow the access size; store data replicated across lanes
    always_comb begin
        be        = 4'b0000;
        wdata_rep = '0;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            2'b10: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = '0;
            end
        endcase
    end

    // Move the addressed lane down to bit 0, then sign or zero extend
    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'b0, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'b0, shifted[15:0]};
            F3_W:    load_data = rdata;
            default: load_data = '0;
        endcase
    end

    // Conflicting op, reserved funct3, unsigned store, or misaligned address
    always_comb begin
        bad = 1'b0;
        if (is_read && is_write)
            bad = 1'b1;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
            bad = 1'b1;
        if (is_write && (funct3 > F3_W))
            bad = 1'b1;
        if ((funct3[1:0] == 2'b01) && addr_lo[0])
            bad = 1'b1;
        if ((funct3 == F3_W) && (addr_lo != 2'b00))
            bad = 1'b1;
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: drives the data-memory req/gnt/rvalid handshake,
// stalls upstream while an access is outstanding and feeds MEM/WB.
module mem_stage_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] wb_mem_r_data,
    output logic [31:0] wb_alu_result,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg,
    output logic        addr_err,
    output logic        bus_err
);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            to_q, to_d;
    logic            mem_op, expired;
    logic [3:0]      lsu_be;
    logic [XLEN-1:0] lsu_wdata, lsu_load;
    logic            lsu_bad;

    lsu_align u_align (
        .is_read   (ex_mem_read),
        .is_write  (ex_mem_write),
        .funct3    (ex_funct3),
        .addr_lo   (ex_addr[1:0]),
        .wdata     (ex_wdata),
        .rdata     (dmem_rdata),
        .be        (lsu_be),
        .wdata_rep (lsu_wdata),
        .load_data (lsu_load),
        .bad       (lsu_bad)
    );

    assign mem_op  = ex_valid & (ex_mem_read | ex_mem_write);
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign expired = (TIMEOUT_CYCLES != 0) && (cnt_inc >= CNT_W'(TIMEOUT_CYCLES));

    // State, wait counter, captured load data and timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            to_q    <= to_d;
        end
    end

    // Next-state and all combinational outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        to_d          = to_q;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        dmem_addr     = '0;
        dmem_be       = 4'b0000;
        dmem_wdata    = '0;
        mem_stall     = 1'b0;
        addr_err      = 1'b0;
        bus_err       = 1'b0;
        wb_reg_write  = 1'b0;
        wb_mem_r_data = rdata_q;
        wb_alu_result = ex_addr;
        wb_rd         = ex_rd;
        wb_mem_to_reg = ex_mem_to_reg;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                to_d  = 1'b0;
                if (!mem_op) begin
                    wb_reg_write = ex_valid & ex_reg_write;
                end else if (lsu_bad) begin
                    addr_err = 1'b1;
                end else begin
                    dmem_req   = 1'b1;
                    dmem_we    = ex_mem_write;
                    dmem_addr  = {ex_addr[31:2], 2'b00};
                    dmem_be    = lsu_be;
                    dmem_wdata = ex_mem_write ? lsu_wdata : '0;
                    mem_stall  = 1'b1;
                    rdata_d    = '0;
                    if (dmem_gnt)
                        state_d = ex_mem_write ? S_DONE : S_RSP;
                    else
                        state_d = S_REQ;
                end
            end

            S_REQ: begin
                dmem_req   = 1'b1;
                dmem_we    = ex_mem_write;
                dmem_addr  = {ex_addr[31:2], 2'b00};
                dmem_be    = lsu_be;
                dmem_wdata = ex_mem_write ? lsu_wdata : '0;
                mem_stall  = 1'b1;
                cnt_d      = cnt_inc;
                if (dmem_gnt) begin
                    state_d = ex_mem_write ? S_DONE : S_RSP;
                end else if (expired) begin
                    bus_err = 1'b1;
                    to_d    = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_RSP: begin
                mem_stall = 1'b1;
                cnt_d     = cnt_inc;
                if (dmem_rvalid) begin
                    rdata_d = lsu_load;
                    state_d = S_DONE;
                end else if (expired) begin
                    bus_err = 1'b1;
                    to_d    = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                wb_reg_write = ex_valid & ex_reg_write & ~to_q;
                rdata_d      = '0;
                cnt_d        = '0;
                to_d         = 1'b0;
                state_d      = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller for the 5-stage RISC-V pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register, runs the req/gnt/rvalid handshake to data memory for loads and stores, and stalls the upstream pipeline while an access is outstanding. It inserts bubbles into MEM/WB during the stall, aligns and extends load data, and flags misaligned/illegal accesses and bus timeouts.

## Interface
- TIMEOUT_CYCLES, 255: wait cycles in REQ+RSP before bus error; 0 disables timeout.
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_mem_read / ex_mem_write  in  1  load / store
- ex_funct3  in  3  access size/sign (RISC-V load/store funct3)
- ex_addr  in  32  effective address (ALU result)
- ex_wdata  in  32  store data (rs2)
- ex_rd  in  5 ; ex_reg_write  in  1 ; ex_mem_to_reg  in  1  writeback controls
- dmem_req  out  1 ; dmem_we  out  1 ; dmem_addr  out  32 (word-aligned) ; dmem_be  out  4 ; dmem_wdata  out  32
- dmem_gnt  in  1  request accepted ; dmem_rvalid  in  1  read data valid ; dmem_rdata  in  32
- mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- wb_mem_r_data  out  32  aligned, extended load data
- wb_alu_result  out  32 ; wb_rd  out  5 ; wb_reg_write  out  1 ; wb_mem_to_reg  out  1  to MEM/WB inputs
- addr_err  out  1  one-cycle pulse: misaligned/illegal access
- bus_err  out  1  one-cycle pulse: timeout

## Operation
- FSM states IDLE, REQ, RSP, DONE; reset -> IDLE, timeout counter 0, captured data 0.
- mem_op = ex_valid & (ex_mem_read | ex_mem_write). bad = both read and write set, funct3 in {011,110,111} (store: funct3 > 010), halfword with addr[0]=1, or word with addr[1:0]!=0.
- IDLE, no mem_op: pass-through; wb_* = ex_* (wb_reg_write = ex_valid & ex_reg_write), mem_stall=0.
- IDLE, mem_op & bad: no request; addr_err=1, wb_reg_write=0, mem_stall=0.
- IDLE, mem_op & !bad: dmem_req=1, mem_stall=1, wb_reg_write=0; gnt -> store: DONE, load: RSP; no gnt -> REQ.
- REQ: dmem_req=1 with stable addr/we/be/wdata until gnt; transitions as IDLE.
- RSP: on dmem_rvalid capture formatted data -> DONE. rvalid outside RSP ignored.
- DONE: mem_stall=0; wb_* = ex_* with wb_mem_r_data = captured data (0 for stores); -> IDLE.
- Timeout: counter increments every REQ/RSP cycle; if it reaches TIMEOUT_CYCLES, bus_err=1, go to DONE with wb_reg_write forced 0; late rvalid dropped.
- Store lanes: SB be=0001<<addr[1:0], wdata = byte replicated x4; SH be=0011<<(2*addr[1]), halfword replicated x2; SW be=1111.
- Load extract: LB/LH sign-extend, LBU/LHU zero-extend, lane selected by addr[1:0]; LW passes.
- dmem_addr = {ex_addr[31:2],2'b00}; dmem_we = ex_mem_write; dmem_* are don't-care when dmem_req=0 but driven 0.

## Timing
- All outputs other than captured data, state, counter are combinational from state and ex_* inputs; captured data registered on rvalid.
- Zero-wait load (gnt in cycle 0, rvalid cycle 1): stall cycles 0-1, DONE cycle 2 -> 2 stall cycles. Zero-wait store: 1 stall cycle.
- Non-memory instruction: 0 stall cycles.
- ex_* inputs must be stable while mem_stall=1 (EX/MEM held); upstream advances at end of DONE.
- Reset mid-transaction: immediate return to IDLE, all registered state cleared, outstanding access abandoned (memory reset with core).

## Structure
- Package mem_ctrl_pkg: state enum, funct3 localparams (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101).
- Sub-module lsu_align (combinational): store byte-enable/data replication, load lane extract/extension, bad-access detection.

## Test plan
- ADD, ex_alu_result=0x1234 -> wb_alu_result=0x1234, wb_reg_write=1 same cycle, mem_stall never 1.
- LB addr 0x103, gnt immediate, rdata=0x80FF_0000 next cycle -> 2 stall cycles, wb_mem_r_data=0xFFFF_FF80 in DONE.
- SH addr 0x102, wdata 0xABCD, gnt after 3 cycles -> dmem_be=1100, dmem_wdata=0xABCD_ABCD, req held 4 cycles, then DONE.
- LW addr 0x101 -> addr_err pulse, dmem_req=0, no stall, wb_reg_write=0.
- TIMEOUT_CYCLES=4, load never gets rvalid -> bus_err after 4 wait cycles, wb_reg_write=0, later rvalid ignored.
- reset asserted in RSP -> next cycle IDLE, mem_stall=0, wb_mem_r_data=0.
